mult_sequencer: RTL

Sequential unsigned N×N multiplier controller built around a single 2×2 partial-product multiplier and half-adder datapath. It splits each operand into 2-bit digits, feeds one digit pair per clock to the 2×2 multiplier, and shifts and accumulates the 4-bit partial products into a 2N-bit result. It sits between a requester issuing start/operand pulses and the shared 2×2 multiplier, owning that multiplier's inputs and the accumulation sequencing.

---
 rtl/mult_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mult_sequencer.sv
// Sequential unsigned N x N multiplier built around one 2x2 half-adder multiplier.
// Each operand is split into 2-bit digits. One digit pair is multiplied per clock,
// and the shifted partial products are accumulated into a 2N-bit result.
module mult_sequencer #(
    parameter int unsigned N = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [N-1:0]     a_i,
    input  logic [N-1:0]     b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [2*N-1:0]   product_o
);

    localparam int unsigned D  = N / 2;
    localparam int unsigned PW = 2 * N;
    localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    a_reg_q, a_reg_d;
    logic [N-1:0]    b_reg_q, b_reg_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   i_q, i_d;
    logic [CW-1:0]   j_q, j_d;
    logic [PW-1:0]   product_q, product_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [1:0]      a_dig_c;
    logic [1:0]      b_dig_c;
    logic [3:0]      pp_c;
    logic            hs1_c, hc1_c, hs2_c, hc2_c;
    logic [CW:0]     pos_c;
    logic [PW-1:0]   pp_shift_c;
    logic [PW-1:0]   sum_c;
    logic            last_i_c, last_j_c;

    // Select the current digit pair from the captured operands.
    always_comb begin
        a_dig_c = 2'(a_reg_q >> {i_q, 1'b0});
        b_dig_c = 2'(b_reg_q >> {j_q, 1'b0});
    end

    // 2x2 multiplier: four AND terms combined through two half adders.
    always_comb begin
        hs1_c = (a_dig_c[1] & b_dig_c[0]) ^ (a_dig_c[0] & b_dig_c[1]);
        hc1_c = (a_dig_c[1] & b_dig_c[0]) & (a_dig_c[0] & b_dig_c[1]);
        hs2_c = (a_dig_c[1] & b_dig_c[1]) ^ hc1_c;
        hc2_c = (a_dig_c[1] & b_dig_c[1]) & hc1_c;
        pp_c  = {hc2_c, hs2_c, hs1_c, a_dig_c[0] & b_dig_c[0]};
    end

    // Weight the partial product by 4^(i+j) and add it to the running sum.
    always_comb begin
        pos_c      = (CW + 1)'(i_q) + (CW + 1)'(j_q);
        pp_shift_c = PW'(pp_c) << {pos_c, 1'b0};
        sum_c      = acc_q + pp_shift_c;
        last_i_c   = (i_q == CW'(D - 1));
        last_j_c   = (j_q == CW'(D - 1));
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        a_reg_d   = a_reg_q;
        b_reg_d   = b_reg_q;
        acc_d     = acc_q;
        i_d       = i_q;
        j_d       = j_q;
        product_d = product_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_reg_d = a_i;
                    b_reg_d = b_i;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = sum_c;
                if (last_j_c) begin
                    j_d = '0;
                    if (last_i_c) begin
                        i_d       = '0;
                        product_d = sum_c;
                        state_d   = ST_DONE;
                    end else begin
                        i_d = i_q + CW'(1);
                    end
                end else begin
                    j_d = j_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            a_reg_q   <= '0;
            b_reg_q   <= '0;
            acc_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_reg_q   <= a_reg_d;
            b_reg_q   <= b_reg_d;
            acc_q     <= acc_d;
            i_q       <= i_d;
            j_q       <= j_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;

endmodule
